spi_dev_proto: RTL and testbench
================================

# spi_dev_proto

Byte-level protocol stage directly downstream of `spi_dev_core`, in the `clk` domain. Turns the core's raw MOSI byte stream and chip-select events into framed commands: first byte = command code, remaining bytes = payload. Sources the MISO byte stream from a local response FIFO filled by user logic, advancing on each core `usr_miso_ack`.

## Interface
- `RESP_DEPTH`, 16: response FIFO depth in bytes; power of two, 2..256.
- `CNT_W`, 8: payload byte counter width.

- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous reset, active-low. All state clears on assertion; deassertion is synchronous to `clk` upstream.
- `usr_mosi_data` in 8: received byte from core.
- `usr_mosi_stb` in 1: one-cycle strobe, `usr_mosi_data` valid.
- `usr_miso_data` out 8: byte the core shifts out next.
- `usr_miso_ack` in 1: one-cycle pulse, core latched `usr_miso_data`.
- `csn_state` in 1: synchronised CS_n level (1 = idle).
- `csn_rise` / `csn_fall` in 1: one-cycle CS_n edge pulses.
- `cmd_code` out 8: latched command byte, held until next command.
- `cmd_start` out 1: one-cycle pulse, `cmd_code` newly valid.
- `cmd_data` out 8: latest payload byte.
- `cmd_stb` out 1: one-cycle pulse, `cmd_data` valid.
- `cmd_cnt` out CNT_W: payload bytes received this command, saturating.
- `cmd_end` out 1: one-cycle pulse at end of a framed command.
- `resp_data` in 8 / `resp_valid` in 1 / `resp_ready` out 1: valid/ready push into response FIFO.
- `irq` in 1: user interrupt level, reported in status byte.
- `underflow` out 1: sticky; MISO byte requested with FIFO empty. Cleared at `csn_fall`.

## Operation
- FSM states IDLE, CMD, DATA. Reset -> IDLE.
- IDLE: `csn_fall` -> CMD. `usr_mosi_stb` ignored.
- CMD: `usr_mosi_stb` -> latch `cmd_code`, pulse `cmd_start`, clear `cmd_cnt`, -> DATA. `csn_rise` -> IDLE, no pulses.
- DATA: `usr_mosi_stb` -> `cmd_data` = byte, pulse `cmd_stb`, `cmd_cnt` += 1, saturating at all-ones. `csn_rise` -> pulse `cmd_end`, -> IDLE.
- `csn_fall` in CMD/DATA: protocol error recovery; treated as `csn_rise` then `csn_fall`. `cmd_end` pulses if in DATA; next state CMD.
- MISO source:
  - While `csn_state`=1: `usr_miso_data` holds the status byte (see Configuration).
  - On `usr_miso_ack`: if FIFO non-empty, pop and load head; else load 8'hFF and set `underflow`.
- FIFO: `resp_ready` = not full. Push when `resp_valid & resp_ready`. Push and pop in the same cycle are both honoured; occupancy is unchanged.
- At `csn_rise` the FIFO is flushed; a push in the same cycle is discarded.

## Timing
- Reset values: `usr_miso_data`=8'h00, `cmd_code`=0, `cmd_data`=0, `cmd_cnt`=0, all pulses 0, `underflow`=0, `resp_ready`=1.
- All outputs registered.
- `cmd_start` / `cmd_stb` assert one cycle after the `usr_mosi_stb` cycle. `cmd_end` asserts one cycle after `csn_rise`.
- `usr_mosi_stb` and `csn_rise` in the same cycle: byte processed first, so `cmd_stb` (or `cmd_start`) at +1. `cmd_end` is delayed to +2, never coincident with `cmd_stb`.
- `usr_miso_data` updates on the cycle after `usr_miso_ack`. Core guarantees ≥4 `clk` between acks.
- A FIFO push is visible to a pop one cycle later; FIFO is not fall-through.

## Configuration
- `SPI_DEV_PROTO_STATUS_EN` defined: idle/first MISO byte = {5'b0, `underflow`, FIFO non-empty, `irq`}, sampled every cycle while `csn_state`=1.
- Not defined: idle/first MISO byte is constant 8'h00. `irq` is ignored, and `underflow` still operates.

## Structure
- Package `spi_dev_pkg`: FSM state encoding, `MISO_IDLE_BYTE` (8'h00), `MISO_UNDERFLOW_BYTE` (8'hFF).
- Sub-module `spi_dev_resp_fifo`: synchronous FIFO with parameter `DEPTH`, push/pop/flush, full/empty outputs, registered read data.

## Test plan
- CS low; bytes 0x9F, 0x01, 0x02; CS high -> `cmd_start` with `cmd_code`=0x9F; two `cmd_stb` carrying 0x01, 0x02; `cmd_cnt`=2; one `cmd_end`.
- CS low then high with no bytes -> no `cmd_start` / `cmd_stb` / `cmd_end`.
- Push 0xC1, 0xC2 before CS low; 3 acks -> MISO sequence status, 0xC1, 0xC2, then 0xFF with `underflow`=1. `underflow` clears at next `csn_fall`.
- With `SPI_DEV_PROTO_STATUS_EN`, `irq`=1, FIFO holding 1 byte -> status byte 0x03. Without the macro -> 0x00.
- Push `RESP_DEPTH`+1 bytes -> `resp_ready`=0 after `RESP_DEPTH`. Push on same cycle as `csn_rise` -> FIFO empty afterwards.
- `usr_mosi_stb` coincident with `csn_rise` -> `cmd_stb` at +1, `cmd_end` at +2. Assert `rst_n` mid-DATA -> all outputs at reset values immediately.

Source files
------------

// File: rtl/spi_dev_pkg.sv
// Shared types and constants for the SPI device protocol stage.
package spi_dev_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_dev_state_e;

    localparam logic [7:0] MISO_IDLE_BYTE      = 8'h00;
    localparam logic [7:0] MISO_UNDERFLOW_BYTE = 8'hFF;

    function automatic logic [7:0] status_byte(input logic underflow,
                                               input logic non_empty,
                                               input logic irq);
        return {5'b0, underflow, non_empty, irq};
    endfunction

endpackage

// File: rtl/spi_dev_resp_fifo.sv
// Response byte FIFO: push/pop/flush, registered full/empty, and a registered
// head byte (rd_data) that always shows the oldest entry.
module spi_dev_resp_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] wr_data,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [AW:0]   count, count_nxt;
    logic          push_ok, pop_ok;

    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_comb begin
        rd_ptr_nxt = pop_ok ? rd_ptr + PTR_ONE : rd_ptr;
        count_nxt  = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= 8'h00;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= 8'h00;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            full   <= (count_nxt == FULL_CNT);
            empty  <= (count_nxt == '0);
            // Bypass covers a push landing in the slot that becomes the new head.
            rd_data <= (push_ok && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/spi_dev_proto.sv
// Byte-level SPI device protocol: frames MOSI bytes into commands, sources MISO
// from a response FIFO. Define SPI_DEV_PROTO_STATUS_EN for a live status byte.
module spi_dev_proto
    import spi_dev_pkg::*;
#(
    parameter int RESP_DEPTH = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       usr_mosi_data,
    input  logic             usr_mosi_stb,
    output logic [7:0]       usr_miso_data,
    input  logic             usr_miso_ack,
    input  logic             csn_state,
    input  logic             csn_rise,
    input  logic             csn_fall,
    output logic [7:0]       cmd_code,
    output logic             cmd_start,
    output logic [7:0]       cmd_data,
    output logic             cmd_stb,
    output logic [CNT_W-1:0] cmd_cnt,
    output logic             cmd_end,
    input  logic [7:0]       resp_data,
    input  logic             resp_valid,
    output logic             resp_ready,
    input  logic             irq,
    output logic             underflow,
    output logic [1:0]       fsm_state
);

    localparam logic [CNT_W-1:0] CMD_CNT_ONE = 1;

    spi_dev_state_e state;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_head;
    logic [7:0]     idle_byte;
    logic           in_data, frame_ends, end_pend;

    spi_dev_resp_fifo #(.DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (resp_data),
        .push    (resp_valid),
        .pop     (usr_miso_ack),
        .flush   (csn_rise),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign resp_ready = ~fifo_full;
    assign fsm_state  = state;

`ifdef SPI_DEV_PROTO_STATUS_EN
    assign idle_byte = status_byte(underflow, ~fifo_empty, irq);
`else
    logic irq_unused;
    assign irq_unused = irq;
    assign idle_byte  = MISO_IDLE_BYTE;
`endif

    // A byte arriving in CMD moves us into DATA, so an edge in that same cycle closes a frame.
    assign in_data    = (state == ST_DATA) || ((state == ST_CMD) && usr_mosi_stb);
    assign frame_ends = (csn_rise || csn_fall) && in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cmd_code  <= 8'h00;
            cmd_data  <= 8'h00;
            cmd_cnt   <= '0;
            cmd_start <= 1'b0;
            cmd_stb   <= 1'b0;
            cmd_end   <= 1'b0;
            end_pend  <= 1'b0;
        end else begin
            cmd_start <= 1'b0;
            cmd_stb   <= 1'b0;
            cmd_end   <= end_pend;
            end_pend  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (csn_fall) state <= ST_CMD;
                end
                ST_CMD, ST_DATA: begin
                    if (usr_mosi_stb) begin
                        if (state == ST_CMD) begin
                            cmd_code  <= usr_mosi_data;
                            cmd_start <= 1'b1;
                            cmd_cnt   <= '0;
                        end else begin
                            cmd_data <= usr_mosi_data;
                            cmd_stb  <= 1'b1;
                            if (cmd_cnt != '1) cmd_cnt <= cmd_cnt + CMD_CNT_ONE;
                        end
                        state <= ST_DATA;
                    end
                    // Keep cmd_end off the cycle that carries the final byte's pulse.
                    if (frame_ends) begin
                        if (usr_mosi_stb) end_pend <= 1'b1;
                        else              cmd_end  <= 1'b1;
                    end
                    if (csn_fall)      state <= ST_CMD;
                    else if (csn_rise) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            usr_miso_data <= MISO_IDLE_BYTE;
            underflow     <= 1'b0;
        end else begin
            if (csn_fall) underflow <= 1'b0;
            if (usr_miso_ack) begin
                if (fifo_empty) begin
                    usr_miso_data <= MISO_UNDERFLOW_BYTE;
                    underflow     <= 1'b1;
                end else begin
                    usr_miso_data <= fifo_head;
                end
            end else if (csn_state) begin
                usr_miso_data <= idle_byte;
            end
        end
    end

endmodule

// File: tb/tb_spi_dev_proto.sv
// Directed bench for spi_dev_proto; command events are checked against an expected queue.
module tb_spi_dev_proto;

    localparam int RESP_DEPTH = 16;
    localparam int CNT_W      = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       usr_mosi_data;
    logic             usr_mosi_stb;
    logic [7:0]       usr_miso_data;
    logic             usr_miso_ack;
    logic             csn_state, csn_rise, csn_fall;
    logic [7:0]       cmd_code, cmd_data;
    logic             cmd_start, cmd_stb, cmd_end;
    logic [CNT_W-1:0] cmd_cnt;
    logic [7:0]       resp_data;
    logic             resp_valid, resp_ready;
    logic             irq, underflow;
    logic [1:0]       fsm_state;

    int errors = 0;
    int checks = 0;
    // Event tokens: {kind, value}; kind 1 = start/code, 2 = stb/data, 3 = end/count.
    logic [11:0] exp_q[$];

    spi_dev_proto #(.RESP_DEPTH(RESP_DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .usr_mosi_data (usr_mosi_data),
        .usr_mosi_stb  (usr_mosi_stb),
        .usr_miso_data (usr_miso_data),
        .usr_miso_ack  (usr_miso_ack),
        .csn_state     (csn_state),
        .csn_rise      (csn_rise),
        .csn_fall      (csn_fall),
        .cmd_code      (cmd_code),
        .cmd_start     (cmd_start),
        .cmd_data      (cmd_data),
        .cmd_stb       (cmd_stb),
        .cmd_cnt       (cmd_cnt),
        .cmd_end       (cmd_end),
        .resp_data     (resp_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .irq           (irq),
        .underflow     (underflow),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_take(input logic [11:0] got);
        logic [11:0] want;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
        chk("sb_event", {20'h0, got}, {20'h0, want});
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (cmd_start) sb_take({4'd1, cmd_code});
            if (cmd_stb)   sb_take({4'd2, cmd_data});
            if (cmd_end)   sb_take({4'd3, cmd_cnt});
        end
    end

    function automatic logic [7:0] exp_status(input logic uf, input logic ne, input logic irq_l);
        logic [7:0] s;
        s = {5'b0, uf, ne, irq_l};
`ifndef SPI_DEV_PROTO_STATUS_EN
        s = 8'h00;
`endif
        return s;
    endfunction

    // ---------------- drivers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cs_low();
        csn_fall = 1'b1; csn_state = 1'b0;
        cyc(1);
        csn_fall = 1'b0;
    endtask

    task automatic cs_high();
        csn_rise = 1'b1; csn_state = 1'b1;
        cyc(1);
        csn_rise = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        usr_mosi_data = b; usr_mosi_stb = 1'b1;
        cyc(1);
        usr_mosi_stb = 1'b0;
        cyc(1);
    endtask

    task automatic push_resp(input logic [7:0] b);
        resp_data = b; resp_valid = 1'b1;
        cyc(1);
        resp_valid = 1'b0;
    endtask

    task automatic do_ack(input string tag, input logic [7:0] exp);
        usr_miso_ack = 1'b1;
        cyc(1);
        usr_miso_ack = 1'b0;
        chk(tag, {24'h0, usr_miso_data}, {24'h0, exp});
        cyc(3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; usr_mosi_data = 8'h00; usr_mosi_stb = 1'b0; usr_miso_ack = 1'b0;
        csn_state = 1'b1; csn_rise = 1'b0; csn_fall = 1'b0;
        resp_data = 8'h00; resp_valid = 1'b0; irq = 1'b0;
        cyc(3);
        chk("rst_miso", {24'h0, usr_miso_data}, 32'h00);
        chk("rst_code", {24'h0, cmd_code}, 32'h00);
        chk("rst_data", {24'h0, cmd_data}, 32'h00);
        chk("rst_cnt", {24'h0, cmd_cnt}, 32'h00);
        chk("rst_pulses", {29'h0, cmd_start, cmd_stb, cmd_end}, 32'h0);
        chk("rst_uf", {31'h0, underflow}, 32'h0);
        chk("rst_ready", {31'h0, resp_ready}, 32'h1);
        chk("rst_state", {30'h0, fsm_state}, 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Basic framed command
        cs_low();
        chk("state_cmd", {30'h0, fsm_state}, 32'h1);
        exp_q.push_back({4'd1, 8'h9F}); send_byte(8'h9F);
        exp_q.push_back({4'd2, 8'h01}); send_byte(8'h01);
        exp_q.push_back({4'd2, 8'h02}); send_byte(8'h02);
        exp_q.push_back({4'd3, 8'h02}); cs_high();
        cyc(3);
        chk("cmd1_code", {24'h0, cmd_code}, 32'h9F);
        chk("cmd1_cnt", {24'h0, cmd_cnt}, 32'h02);
        chk("cmd1_data", {24'h0, cmd_data}, 32'h02);
        chk("cmd1_drain", exp_q.size(), 0);

        // Empty frame: no events at all
        cs_low(); cyc(2); cs_high(); cyc(3);
        chk("empty_code_held", {24'h0, cmd_code}, 32'h9F);
        chk("empty_state", {30'h0, fsm_state}, 32'h0);

        // MISO sequence with underflow
        push_resp(8'hC1); push_resp(8'hC2);
        cyc(2);
        chk("status_pre", {24'h0, usr_miso_data}, {24'h0, exp_status(1'b0, 1'b1, 1'b0)});
        cs_low();
        chk("status_held", {24'h0, usr_miso_data}, {24'h0, exp_status(1'b0, 1'b1, 1'b0)});
        do_ack("miso_c1", 8'hC1);
        do_ack("miso_c2", 8'hC2);
        chk("uf_before", {31'h0, underflow}, 32'h0);
        do_ack("miso_ff", 8'hFF);
        chk("uf_set", {31'h0, underflow}, 32'h1);
        cs_high(); cyc(2);
        chk("uf_sticky", {31'h0, underflow}, 32'h1);
        chk("status_uf", {24'h0, usr_miso_data}, {24'h0, exp_status(1'b1, 1'b0, 1'b0)});
        cs_low();
        chk("uf_clear", {31'h0, underflow}, 32'h0);
        cs_high(); cyc(2);

        // Status byte with irq and one queued byte
        irq = 1'b1;
        push_resp(8'hA5);
        cyc(2);
        chk("status_irq", {24'h0, usr_miso_data}, {24'h0, exp_status(1'b0, 1'b1, 1'b1)});
        cs_low();
        do_ack("miso_a5", 8'hA5);
        cs_high();
        irq = 1'b0;
        cyc(2);

        // Fill past depth
        resp_valid = 1'b1;
        for (int i = 0; i <= RESP_DEPTH; i++) begin
            resp_data = 8'(8'h40 + i);
            chk("fill_ready", {31'h0, resp_ready}, {31'h0, (i < RESP_DEPTH)});
            cyc(1);
        end
        resp_valid = 1'b0;
        chk("full_ready", {31'h0, resp_ready}, 32'h0);
        cs_low();
        do_ack("fill_head", 8'h40);
        chk("ready_after_pop", {31'h0, resp_ready}, 32'h1);
        // Push coincident with csn_rise is discarded by the flush
        resp_data = 8'h77; resp_valid = 1'b1; csn_rise = 1'b1; csn_state = 1'b1;
        cyc(1);
        resp_valid = 1'b0; csn_rise = 1'b0;
        cyc(2);
        chk("flush_ready", {31'h0, resp_ready}, 32'h1);
        cs_low();
        do_ack("flush_empty", 8'hFF);
        chk("flush_uf", {31'h0, underflow}, 32'h1);
        cs_high(); cyc(2);

        // Byte coincident with csn_rise
        cs_low();
        exp_q.push_back({4'd1, 8'h5A}); send_byte(8'h5A);
        exp_q.push_back({4'd2, 8'h3C});
        exp_q.push_back({4'd3, 8'h01});
        usr_mosi_data = 8'h3C; usr_mosi_stb = 1'b1; csn_rise = 1'b1; csn_state = 1'b1;
        cyc(1);
        usr_mosi_stb = 1'b0; csn_rise = 1'b0;
        chk("coinc_stb", {30'h0, cmd_stb, cmd_end}, 32'h2);
        cyc(1);
        chk("coinc_end", {30'h0, cmd_stb, cmd_end}, 32'h1);
        cyc(2);

        // Payload counter saturation
        cs_low();
        exp_q.push_back({4'd1, 8'h03}); send_byte(8'h03);
        for (int i = 0; i < 257; i++) begin
            exp_q.push_back({4'd2, 8'(i)});
            send_byte(8'(i));
        end
        chk("sat_cnt", {24'h0, cmd_cnt}, 32'hFF);
        exp_q.push_back({4'd3, 8'hFF}); cs_high();
        cyc(3);

        // csn_fall while in DATA restarts the frame
        cs_low();
        exp_q.push_back({4'd1, 8'h10}); send_byte(8'h10);
        exp_q.push_back({4'd2, 8'h11}); send_byte(8'h11);
        exp_q.push_back({4'd3, 8'h01});
        csn_fall = 1'b1; cyc(1); csn_fall = 1'b0;
        cyc(1);
        chk("recover_state", {30'h0, fsm_state}, 32'h1);
        exp_q.push_back({4'd1, 8'h20}); send_byte(8'h20);
        exp_q.push_back({4'd3, 8'h00}); cs_high();
        cyc(3);
        chk("recover_drain", exp_q.size(), 0);

        // Asynchronous reset mid-DATA
        cs_low();
        exp_q.push_back({4'd1, 8'hAB}); send_byte(8'hAB);
        exp_q.push_back({4'd2, 8'hCD}); send_byte(8'hCD);
        push_resp(8'h99);
        chk("pre_rst_state", {30'h0, fsm_state}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_code", {24'h0, cmd_code}, 32'h00);
        chk("arst_data", {24'h0, cmd_data}, 32'h00);
        chk("arst_cnt", {24'h0, cmd_cnt}, 32'h00);
        chk("arst_miso", {24'h0, usr_miso_data}, 32'h00);
        chk("arst_pulses", {28'h0, cmd_start, cmd_stb, cmd_end, underflow}, 32'h0);
        chk("arst_ready", {31'h0, resp_ready}, 32'h1);
        chk("arst_state", {30'h0, fsm_state}, 32'h0);
        cyc(2);
        csn_state = 1'b1;
        rst_n = 1'b1;
        cyc(3);

        chk("final_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
